// File: rtl/opmatch_pair_sequencer_if.sv
// Record-in / beat-out bus of the operand-match pair sequencer.
// The slave modport is the sequencer; the master modport is the matcher plus the MAC side.
interface opmatch_pair_sequencer_if #(
   parameter int BITMASK_LENGTH = 8,
   parameter int INDEX_BITWIDTH = 3,
   parameter int COUNT_BITWIDTH = 4,
   parameter int LANES          = 2
);
   logic                                     in_valid;
   logic                                     in_ready;
   logic [COUNT_BITWIDTH-1:0]                in_count;
   logic [BITMASK_LENGTH*INDEX_BITWIDTH-1:0] in_idx_a;
   logic [BITMASK_LENGTH*INDEX_BITWIDTH-1:0] in_idx_w;
   logic                                     in_last_block;
   logic                                     out_valid;
   logic                                     out_ready;
   logic [LANES-1:0]                         out_lane_valid;
   logic [LANES*INDEX_BITWIDTH-1:0]          out_idx_a;
   logic [LANES*INDEX_BITWIDTH-1:0]          out_idx_w;
   logic                                     out_last;
   logic                                     out_flush;

   modport slave (
      input  in_valid, in_count, in_idx_a, in_idx_w, in_last_block, out_ready,
      output in_ready, out_valid, out_lane_valid, out_idx_a, out_idx_w, out_last, out_flush
   );

   modport master (
      output in_valid, in_count, in_idx_a, in_idx_w, in_last_block, out_ready,
      input  in_ready, out_valid, out_lane_valid, out_idx_a, out_idx_w, out_last, out_flush
   );
endinterface

// File: rtl/opmatch_pair_sequencer.sv
// Turns one match record per sparse block into LANES-wide index-pair beats for the MACs.
// Define OPMATCH_SEQ_STATS_EN to add saturating pair/beat counters with stat_clear.
module opmatch_pair_sequencer #(
   parameter int BITMASK_LENGTH = 8,
   parameter int INDEX_BITWIDTH = 3,
   parameter int COUNT_BITWIDTH = 4,
   parameter int LANES          = 2
) (
   input  logic clock,
   input  logic reset,
`ifdef OPMATCH_SEQ_STATS_EN
   input  logic        stat_clear,
   output logic [31:0] stat_pairs,
   output logic [31:0] stat_beats,
`endif
   opmatch_pair_sequencer_if.slave bus
);
   localparam int CURW = COUNT_BITWIDTH + 1;
   localparam int SELW = (BITMASK_LENGTH > 1) ? $clog2(BITMASK_LENGTH) : 1;
   localparam int IW   = INDEX_BITWIDTH;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;

   logic [1:0]      state;
   logic [CURW-1:0] cursor;
   logic [CURW-1:0] heldCount;
   logic            heldLast;
   logic [IW-1:0]   heldA [BITMASK_LENGTH];
   logic [IW-1:0]   heldW [BITMASK_LENGTH];

   logic [CURW-1:0] inCountClamped;
   logic            lastBeat;
   logic            beatLast;
   logic            accept;
   logic            beatFire;

   always_comb begin
      inCountClamped = {1'b0, bus.in_count};
      if (inCountClamped > CURW'(BITMASK_LENGTH)) begin
         inCountClamped = CURW'(BITMASK_LENGTH);
      end
   end

   // The final beat of a record is where the next record can be taken without a bubble.
   assign lastBeat       = (cursor + CURW'(LANES)) >= heldCount;
   assign beatLast       = ((state == ISSUE) && lastBeat) || (state == FLUSH);
   assign bus.in_ready   = !reset && ((state == IDLE) || (beatLast && bus.out_ready));
   assign accept         = bus.in_valid && bus.in_ready;
   assign bus.out_valid  = (state == ISSUE) || (state == FLUSH);
   assign beatFire       = bus.out_valid && bus.out_ready;
   assign bus.out_last   = beatLast;
   assign bus.out_flush  = beatLast && heldLast;

   always_comb begin
      logic [CURW-1:0] pos;
      pos                = '0;
      bus.out_lane_valid = '0;
      bus.out_idx_a      = '0;
      bus.out_idx_w      = '0;
      for (int k = 0; k < LANES; k++) begin
         pos = cursor + CURW'(k);
         if ((state == ISSUE) && (pos < heldCount)) begin
            bus.out_lane_valid[k]     = 1'b1;
            bus.out_idx_a[k*IW +: IW] = heldA[pos[SELW-1:0]];
            bus.out_idx_w[k*IW +: IW] = heldW[pos[SELW-1:0]];
         end
      end
   end

   // Stalls fall out naturally: nothing advances unless a record or beat is accepted.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         cursor    <= '0;
         heldCount <= '0;
         heldLast  <= 1'b0;
         for (int k = 0; k < BITMASK_LENGTH; k++) begin
            heldA[k] <= '0;
            heldW[k] <= '0;
         end
      end else if (accept) begin
         cursor    <= '0;
         heldCount <= inCountClamped;
         heldLast  <= bus.in_last_block;
         for (int k = 0; k < BITMASK_LENGTH; k++) begin
            heldA[k] <= bus.in_idx_a[k*IW +: IW];
            heldW[k] <= bus.in_idx_w[k*IW +: IW];
         end
         if (inCountClamped != '0) begin
            state <= ISSUE;
         end else if (bus.in_last_block) begin
            state <= FLUSH;
         end else begin
            state <= IDLE;
         end
      end else if (beatFire) begin
         if (beatLast) begin
            state <= IDLE;
         end else begin
            cursor <= cursor + CURW'(LANES);
         end
      end
   end

`ifdef OPMATCH_SEQ_STATS_EN
   logic [31:0] beatPairs;
   logic [32:0] pairSum;

   always_comb begin
      beatPairs = '0;
      for (int k = 0; k < LANES; k++) begin
         beatPairs = beatPairs + 32'(bus.out_lane_valid[k]);
      end
      pairSum = {1'b0, stat_pairs} + {1'b0, beatPairs};
   end

   // Saturating counters; clearing wins over a beat landing in the same cycle.
   always_ff @(posedge clock) begin
      if (reset || stat_clear) begin
         stat_pairs <= '0;
         stat_beats <= '0;
      end else if (beatFire) begin
         stat_pairs <= pairSum[32] ? '1 : pairSum[31:0];
         if (stat_beats != '1) begin
            stat_beats <= stat_beats + 32'd1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_opmatch_pair_sequencer.sv
// Randomised bench for opmatch_pair_sequencer against a record-to-beat queue model.
module tb_opmatch_pair_sequencer;
   typedef struct packed {
      logic [1:0] lv;
      logic [5:0] ia;
      logic [5:0] iw;
      logic       last;
      logic       flush;
   } beat_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   testsRun = 0;
   int   testsFailed = 0;
   logic randomReady = 1'b0;
   beat_t expQ [$];

   opmatch_pair_sequencer_if bus ();

`ifdef OPMATCH_SEQ_STATS_EN
   logic        stat_clear = 1'b0;
   logic [31:0] stat_pairs;
   logic [31:0] stat_beats;
   int          modelPairs = 0;
   int          modelBeats = 0;
`endif

   opmatch_pair_sequencer dut (
      .clock      (clock),
      .reset      (reset),
`ifdef OPMATCH_SEQ_STATS_EN
      .stat_clear (stat_clear),
      .stat_pairs (stat_pairs),
      .stat_beats (stat_beats),
`endif
      .bus        (bus.slave)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Expand a record straight from the beat rules: ceil(n/2) beats of consecutive pairs.
   function automatic void pushRecord(input int cnt, input logic [23:0] a, input logic [23:0] w, input logic lb);
      int    n;
      int    nb;
      int    p;
      beat_t b;
      n = (cnt > 8) ? 8 : cnt;
      if (n == 0) begin
         if (lb) begin
            b = '0;
            b.last = 1'b1;
            b.flush = 1'b1;
            expQ.push_back(b);
         end
      end else begin
         nb = (n + 1) / 2;
         for (int bi = 0; bi < nb; bi++) begin
            b = '0;
            for (int k = 0; k < 2; k++) begin
               p = bi * 2 + k;
               if (p < n) begin
                  b.lv[k] = 1'b1;
                  b.ia[k*3 +: 3] = a[p*3 +: 3];
                  b.iw[k*3 +: 3] = w[p*3 +: 3];
               end
            end
            b.last = (bi == nb - 1);
            b.flush = b.last && lb;
            expQ.push_back(b);
         end
      end
   endfunction

   // Inputs are stable from the negedge to the following posedge, so handshakes seen here are real.
   always @(negedge clock) begin
      beat_t exp;
      logic  expReady;
      if (reset) begin
         expQ.delete();
`ifdef OPMATCH_SEQ_STATS_EN
         modelPairs = 0;
         modelBeats = 0;
`endif
         checkOutput("in_ready_reset", 32'(bus.in_ready), 32'd0);
      end else begin
         expReady = (expQ.size() == 0) || ((expQ.size() == 1) && bus.out_ready);
         checkOutput("out_valid", 32'(bus.out_valid), 32'(expQ.size() != 0));
         checkOutput("in_ready", 32'(bus.in_ready), 32'(expReady));
         if (expQ.size() != 0) begin
            exp = expQ[0];
            checkOutput("lane_valid", 32'(bus.out_lane_valid), 32'(exp.lv));
            checkOutput("idx_a", 32'(bus.out_idx_a), 32'(exp.ia));
            checkOutput("idx_w", 32'(bus.out_idx_w), 32'(exp.iw));
            checkOutput("out_last", 32'(bus.out_last), 32'(exp.last));
            checkOutput("out_flush", 32'(bus.out_flush), 32'(exp.flush));
            if (bus.out_valid && bus.out_ready) begin
               void'(expQ.pop_front());
`ifdef OPMATCH_SEQ_STATS_EN
               modelBeats++;
               modelPairs += $countones(exp.lv);
`endif
            end
         end else begin
            checkOutput("lane_valid_idle", 32'(bus.out_lane_valid), 32'd0);
         end
         if (bus.in_valid && bus.in_ready) begin
            pushRecord(int'(bus.in_count), bus.in_idx_a, bus.in_idx_w, bus.in_last_block);
         end
      end
   end

   always @(posedge clock) begin
      #1;
      if (randomReady) begin
         bus.out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Presents one record and returns one step after the edge that accepted it.
   task automatic applyStimulus(input int cnt, input logic [23:0] a, input logic [23:0] w, input logic lb);
      logic ready;
      logic accepted;
      accepted = 1'b0;
      bus.in_valid      = 1'b1;
      bus.in_count      = 4'(cnt);
      bus.in_idx_a      = a;
      bus.in_idx_w      = w;
      bus.in_last_block = lb;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         ready = bus.in_ready;
         @(posedge clock);
         #1;
         if (ready) begin
            accepted = 1'b1;
            break;
         end
      end
      bus.in_valid = 1'b0;
      if (!accepted) begin
         checkOutput("accept_timeout", 32'd0, 32'd1);
      end
   endtask

   task automatic waitIdle();
      logic drained;
      drained = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clock);
         if (expQ.size() == 0) begin
            drained = 1'b1;
            break;
         end
      end
      if (!drained) begin
         checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
      end
      @(posedge clock);
      #1;
   endtask

   function automatic logic [23:0] packIdx(input int e0, input int e1, input int e2, input int e3,
                                           input int e4, input int e5, input int e6, input int e7);
      return {3'(e7), 3'(e6), 3'(e5), 3'(e4), 3'(e3), 3'(e2), 3'(e1), 3'(e0)};
   endfunction

   initial begin
      bus.in_valid      = 1'b0;
      bus.in_count      = '0;
      bus.in_idx_a      = '0;
      bus.in_idx_w      = '0;
      bus.in_last_block = 1'b0;
      bus.out_ready     = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;

      applyStimulus(5, packIdx(1, 3, 4, 6, 7, 0, 0, 0), packIdx(0, 2, 5, 6, 7, 0, 0, 0), 1'b0);
      waitIdle();

      applyStimulus(0, $urandom, $urandom, 1'b0);
      applyStimulus(0, $urandom, $urandom, 1'b1);
      waitIdle();

      applyStimulus(2, $urandom, $urandom, 1'b0);
      applyStimulus(4, $urandom, $urandom, 1'b1);
      waitIdle();

      applyStimulus(8, packIdx(0, 1, 2, 3, 4, 5, 6, 7), packIdx(7, 6, 5, 4, 3, 2, 1, 0), 1'b1);
      @(posedge clock);
      #1;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      bus.out_ready = 1'b1;
      waitIdle();

      applyStimulus(12, $urandom, $urandom, 1'b0);
      waitIdle();

      applyStimulus(6, $urandom, $urandom, 1'b1);
      @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      applyStimulus(1, $urandom, $urandom, 1'b0);
      waitIdle();

      randomReady = 1'b1;
      for (int r = 0; r < 150; r++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clock);
            #1;
         end
         applyStimulus($urandom_range(0, 15), $urandom, $urandom, 1'($urandom_range(0, 1)));
      end
      waitIdle();
      randomReady = 1'b0;

`ifdef OPMATCH_SEQ_STATS_EN
      checkOutput("stat_beats", stat_beats, 32'(modelBeats));
      checkOutput("stat_pairs", stat_pairs, 32'(modelPairs));
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule
